// File: rtl/gate_op_scheduler.sv
// Round-robin scheduler sharing one 12-function gate-evaluation unit among NREQ requesters,
// with a one-entry response register. Define GATE_SCHED_OPCHK_EN to report illegal opcodes.
module gate_op_scheduler #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [4*NREQ-1:0] req_op,
  input  logic [NREQ-1:0]   req_i1,
  input  logic [NREQ-1:0]   req_i2,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [3:0]        rsp_op,
  output logic              rsp_o,
  output logic              rsp_hiz,
  output logic              rsp_err,
  output logic              err_sticky,
  output logic [15:0]       op_cnt
);

  typedef enum logic {ST_EMPTY, ST_FULL} state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [IDW-1:0]  id_q;
  logic [3:0]      op_q;
  logic            o_q, hiz_q;

  logic            slot_free, gnt_found, accept;
  logic [IDW-1:0]  gnt_idx;
  logic [IDW:0]    scan, ptr_inc;
  logic [3:0]      gnt_op;
  logic [1:0]      gnt_res;

  // Returns {hiz, o}; o is forced low whenever the output floats.
  function automatic logic [1:0] gate_eval(input logic [3:0] op, input logic i1, input logic i2);
    logic o, hiz;
    o   = 1'b0;
    hiz = 1'b0;
    case (op)
      4'd0:    o = i1 & i2;
      4'd1:    o = i1 | i2;
      4'd2:    o = ~(i1 & i2);
      4'd3:    o = ~(i1 | i2);
      4'd4:    o = i1 ^ i2;
      4'd5:    o = ~(i1 ^ i2);
      4'd6:    o = i1;
      4'd7:    o = ~i1;
      4'd8:    begin hiz = ~i2; o = i1 & i2;   end
      4'd9:    begin hiz = i2;  o = i1 & ~i2;  end
      4'd10:   begin hiz = ~i2; o = ~i1 & i2;  end
      4'd11:   begin hiz = i2;  o = ~i1 & ~i2; end
      default: hiz = 1'b1;
    endcase
    return {hiz, o};
  endfunction

  assign rsp_valid = (state_q == ST_FULL);
  assign slot_free = ~rsp_valid | rsp_ready;

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan      = '0;
    for (int i = 0; i < NREQ; i++) begin
      scan = {1'b0, ptr_q} + (IDW+1)'(i);
      if (scan >= (IDW+1)'(NREQ)) scan = scan - (IDW+1)'(NREQ);
      if (!gnt_found && req_valid[scan[IDW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan[IDW-1:0];
      end
    end
  end

  // Reset also masks the grant so nothing is offered while rst_n is low.
  assign accept = gnt_found & slot_free & rst_n;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[gnt_idx] = 1'b1;
  end

  assign gnt_op  = req_op[{gnt_idx, 2'b00} +: 4];
  assign gnt_res = gate_eval(gnt_op, req_i1[gnt_idx], req_i2[gnt_idx]);
  assign ptr_inc = {1'b0, gnt_idx} + (IDW+1)'(1);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    if (accept) begin
      state_d = ST_FULL;
      ptr_d   = (ptr_inc == (IDW+1)'(NREQ)) ? '0 : ptr_inc[IDW-1:0];
      cnt_d   = cnt_q + 16'd1;
    end else if (rsp_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      ptr_q   <= '0;
      cnt_q   <= '0;
      id_q    <= '0;
      op_q    <= '0;
      o_q     <= 1'b0;
      hiz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        id_q  <= gnt_idx;
        op_q  <= gnt_op;
        o_q   <= gnt_res[0];
        hiz_q <= gnt_res[1];
      end
    end
  end

  assign rsp_id  = id_q;
  assign rsp_op  = op_q;
  assign rsp_o   = o_q;
  assign rsp_hiz = hiz_q;
  assign op_cnt  = cnt_q;

`ifdef GATE_SCHED_OPCHK_EN
  logic op_illegal, err_q, sticky_q;
  assign op_illegal = gnt_op[3] & gnt_op[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else if (accept) begin
      err_q    <= op_illegal;
      sticky_q <= sticky_q | op_illegal;
    end
  end

  assign rsp_err    = err_q;
  assign err_sticky = sticky_q;
`else
  assign rsp_err    = 1'b0;
  assign err_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_gate_op_scheduler.sv
// Scoreboard bench for gate_op_scheduler: directed stimulus pushes expected responses,
// a negedge monitor pops and compares each consumed response.
module tb_gate_op_scheduler;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

`ifdef GATE_SCHED_OPCHK_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [4*NREQ-1:0] req_op;
  logic [NREQ-1:0]   req_i1;
  logic [NREQ-1:0]   req_i2;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [3:0]        rsp_op;
  logic              rsp_o;
  logic              rsp_hiz;
  logic              rsp_err;
  logic              err_sticky;
  logic [15:0]       op_cnt;

  int checks   = 0;
  int failures = 0;

  // Expected response word: {id, op, o, hiz, err}
  logic [8:0] exp_q[$];

  // Truth tables indexed by {i1,i2}
  logic [3:0] tt_o   [12];
  logic [3:0] tt_hiz [12];

  gate_op_scheduler #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_i1(req_i1), .req_i2(req_i2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_op(rsp_op), .rsp_o(rsp_o), .rsp_hiz(rsp_hiz),
    .rsp_err(rsp_err), .err_sticky(err_sticky), .op_cnt(op_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, queue=%0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic logic [8:0] mk(input int id, input int op, input logic o,
                                    input logic hiz, input logic err);
    logic [1:0] id2;
    logic [3:0] op4;
    id2 = IDW'(id);
    op4 = 4'(op);
    return {id2, op4, o, hiz, err};
  endfunction

  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rsp_unexpected: got id=%0d op=%0d with empty scoreboard", rsp_id, rsp_op);
      end else begin
        chk("rsp", {23'd0, rsp_id, rsp_op, rsp_o, rsp_hiz, rsp_err}, {23'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setreq(input int k, input int op, input logic i1, input logic i2);
    req_op[4*k +: 4] = 4'(op);
    req_i1[k] = i1;
    req_i2[k] = i2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drain();
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (3) step();
    chk("queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    tt_o[0]  = 4'b1000; tt_hiz[0]  = 4'b0000;
    tt_o[1]  = 4'b1110; tt_hiz[1]  = 4'b0000;
    tt_o[2]  = 4'b0111; tt_hiz[2]  = 4'b0000;
    tt_o[3]  = 4'b0001; tt_hiz[3]  = 4'b0000;
    tt_o[4]  = 4'b0110; tt_hiz[4]  = 4'b0000;
    tt_o[5]  = 4'b1001; tt_hiz[5]  = 4'b0000;
    tt_o[6]  = 4'b1100; tt_hiz[6]  = 4'b0000;
    tt_o[7]  = 4'b0011; tt_hiz[7]  = 4'b0000;
    tt_o[8]  = 4'b1000; tt_hiz[8]  = 4'b0101;
    tt_o[9]  = 4'b0100; tt_hiz[9]  = 4'b1010;
    tt_o[10] = 4'b0010; tt_hiz[10] = 4'b0101;
    tt_o[11] = 4'b0001; tt_hiz[11] = 4'b1010;

    // Reset state, with all requesters valid to prove req_ready is masked
    rst_n = 1'b0; rsp_ready = 1'b1; req_valid = '1;
    req_op = '0; req_i1 = '0; req_i2 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_fields", {rsp_id, rsp_op, rsp_o, rsp_hiz, rsp_err}, 0);
    chk("rst_err_sticky", err_sticky, 0);
    chk("rst_op_cnt", op_cnt, 0);
    req_valid = '0;
    rst_n = 1'b1;

    // Opcode sweep from requester 0
    step();
    for (int op = 0; op < 12; op++) begin
      for (int c = 0; c < 4; c++) begin
        logic i1, i2;
        i1 = (c >= 2);
        i2 = (c % 2 == 1);
        setreq(0, op, i1, i2);
        req_valid = 4'b0001;
        exp_q.push_back(mk(0, op, tt_o[op][c], tt_hiz[op][c], 1'b0));
        step();
      end
    end
    req_valid = '0;
    chk("sweep_op_cnt", op_cnt, 48);
    drain();

    // Round robin with everyone valid
    do_reset();
    for (int k = 0; k < NREQ; k++) setreq(k, k, 1'b1, 1'b0);
    req_valid = '1;
    for (int i = 0; i < 8; i++) begin
      logic [3:0] rr_exp;
      @(negedge clk);
      rr_exp = 4'b0001 << (i % 4);
      chk("rr_req_ready", req_ready, rr_exp);
      exp_q.push_back(mk(i % 4, i % 4, ((i % 4) == 1) || ((i % 4) == 2), 1'b0, 1'b0));
      @(posedge clk);
      #1;
    end
    req_valid = '0;
    chk("rr_op_cnt", op_cnt, 8);
    drain();

    // Backpressure and back-to-back refill
    rsp_ready = 1'b0;
    do_reset();
    setreq(0, 4, 1'b1, 1'b0);
    req_valid = 4'b0001;
    exp_q.push_back(mk(0, 4, 1'b1, 1'b0, 1'b0));
    step();
    setreq(1, 5, 1'b1, 1'b1);
    req_valid = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_hold", {rsp_id, rsp_op, rsp_o, rsp_hiz}, {2'd0, 4'd4, 1'b1, 1'b0});
      chk("bp_req_ready", req_ready, 0);
      @(posedge clk);
      #1;
    end
    rsp_ready = 1'b1;
    exp_q.push_back(mk(1, 5, 1'b1, 1'b0, 1'b0));
    @(negedge clk);
    chk("bp_release_ready", req_ready, 4'b0010);
    step();
    req_valid = '0;
    @(negedge clk);
    chk("bp_refill_valid", rsp_valid, 1);
    chk("bp_refill_id", rsp_id, 1);
    drain();

    // Pointer skip with only requesters 1 and 3 valid
    do_reset();
    setreq(1, 6, 1'b1, 1'b0);
    setreq(3, 6, 1'b0, 1'b0);
    req_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      logic [3:0] sk_exp;
      @(negedge clk);
      sk_exp = (i % 2 == 1) ? 4'b1000 : 4'b0010;
      chk("skip_req_ready", req_ready, sk_exp);
      exp_q.push_back(mk((i % 2 == 1) ? 3 : 1, 6, (i % 2 == 0), 1'b0, 1'b0));
      @(posedge clk);
      #1;
    end
    drain();

    // Illegal opcode from requester 2, then a legal one
    do_reset();
    setreq(2, 13, 1'b1, 1'b1);
    req_valid = 4'b0100;
    exp_q.push_back(mk(2, 13, 1'b0, 1'b1, ERR_EN));
    step();
    setreq(2, 0, 1'b1, 1'b1);
    exp_q.push_back(mk(2, 0, 1'b1, 1'b0, 1'b0));
    step();
    req_valid = '0;
    repeat (3) step();
    chk("illegal_sticky", err_sticky, ERR_EN);
    chk("illegal_op_cnt", op_cnt, 2);
    drain();

    // Reset while FULL drops the response; first grant after release is requester 0
    rsp_ready = 1'b0;
    do_reset();
    for (int k = 0; k < NREQ; k++) setreq(k, 0, 1'b0, 1'b0);
    setreq(0, 1, 1'b1, 1'b0);
    req_valid = 4'b0001;
    step();
    @(negedge clk);
    chk("midfull_valid", rsp_valid, 1);
    #1;
    req_valid = '1;
    rst_n = 1'b0;
    #1;
    chk("midfull_rst_valid", rsp_valid, 0);
    chk("midfull_rst_ready", req_ready, 0);
    chk("midfull_rst_cnt", op_cnt, 0);
    chk("midfull_rst_sticky", err_sticky, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_grant", req_ready, 4'b0001);
    exp_q.push_back(mk(0, 1, 1'b1, 1'b0, 1'b0));
    step();
    drain();

    // op_cnt wrap
    do_reset();
    setreq(0, 0, 1'b0, 1'b0);
    req_valid = 4'b0001;
    for (int i = 0; i < 65535; i++) begin
      exp_q.push_back(mk(0, 0, 1'b0, 1'b0, 1'b0));
      step();
    end
    req_valid = '0;
    chk("wrap_cnt_max", op_cnt, 16'hFFFF);
    req_valid = 4'b0001;
    exp_q.push_back(mk(0, 0, 1'b0, 1'b0, 1'b0));
    step();
    req_valid = '0;
    chk("wrap_cnt_zero", op_cnt, 0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
